// File: rtl/imem_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter
//
// Fetch sequencer for the front end. It generates the sequential fetch PC,
// reads the shared instruction memory port and buffers {pc, word} pairs in a
// small prefetch FIFO toward decode. A debug/inspection port shares the same
// memory read port through a two-requester arbiter that never lets debug win
// two consecutive contested cycles.
//
// Ports:
//   clock        in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   mem_addr     out  byte address to instruction memory (bits [1:0] = 00)
//   mem_data     in   instruction memory read data (same-cycle)
//   redirect     in   branch/jump taken: flush FIFO and restart fetch
//   redirect_pc  in   new fetch address when redirect=1
//   inst_valid   out  FIFO head valid
//   inst         out  FIFO head instruction
//   inst_pc      out  byte address of inst
//   inst_ready   in   decode accepts the head this cycle
//   dbg_req      in   debug read request, held until dbg_ack
//   dbg_addr     in   debug byte address, stable while dbg_req is high
//   dbg_ack      out  one-cycle pulse, dbg_data valid
//   dbg_data     out  registered debug read result
// -----------------------------------------------------------------------------
module imem_fetch_arbiter #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_data
);

    localparam int unsigned      PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CntW     = PtrW + 1;
    localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);
    localparam logic [31:0]      AddrSpan = 32'(MEM_WORDS * 4);

    typedef enum logic {
        GntFetch,
        GntDbg
    } grant_e;

    // State
    grant_e            r_last_grant;
    grant_e            w_last_grant_d;
    logic [31:0]       r_fetch_pc;
    logic [CntW-1:0]   r_count;
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic              r_dbg_ack;
    logic [31:0]       r_dbg_data;
    logic [31:0]       r_fifo_inst [DEPTH];
    logic [31:0]       r_fifo_pc   [DEPTH];

    // Combinational
    logic              w_fetch_want;
    logic              w_dbg_want;
    logic              w_grant_dbg;
    logic              w_grant_fetch;
    logic              w_pop;
    logic [31:0]       w_pc_inc;
    logic [31:0]       w_pc_seq;
    logic [31:0]       w_pc_redir;

    // No pop credit: a full FIFO waits for the pop to land before fetching.
    assign w_fetch_want = (r_count < DepthCnt) && !redirect;
    // The ack cycle itself is never granted.
    assign w_dbg_want   = dbg_req && !r_dbg_ack;

    // Debug wins a contested cycle unless it won the previous grant.
    assign w_grant_dbg   = w_dbg_want && (!w_fetch_want || (r_last_grant != GntDbg));
    assign w_grant_fetch = w_fetch_want && !w_grant_dbg;

    assign w_pop = (r_count != '0) && inst_ready && !redirect;

    // fetch_pc is always word aligned and below AddrSpan, so one compare wraps it.
    assign w_pc_inc   = r_fetch_pc + 32'd4;
    assign w_pc_seq   = (w_pc_inc >= AddrSpan) ? 32'd0 : w_pc_inc;
    assign w_pc_redir = (redirect_pc & 32'hFFFF_FFFC) % AddrSpan;

    assign mem_addr = w_grant_dbg ? (dbg_addr & 32'hFFFF_FFFC) : r_fetch_pc;

    assign inst_valid = (r_count != '0);
    assign inst       = r_fifo_inst[r_rptr];
    assign inst_pc    = r_fifo_pc[r_rptr];
    assign dbg_ack    = r_dbg_ack;
    assign dbg_data   = r_dbg_data;

    // Arbiter next state: updates only on a grant.
    always_comb begin
        w_last_grant_d = r_last_grant;
        if (w_grant_dbg) begin
            w_last_grant_d = GntDbg;
        end else if (w_grant_fetch) begin
            w_last_grant_d = GntFetch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= GntFetch;
        end else begin
            r_last_grant <= w_last_grant_d;
        end
    end

    // Fetch PC, FIFO control and debug result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_dbg_ack  <= 1'b0;
            r_dbg_data <= 32'd0;
        end else begin
            r_dbg_ack <= w_grant_dbg;
            if (w_grant_dbg) begin
                r_dbg_data <= mem_data;
            end

            if (redirect) begin
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_fetch_pc <= w_pc_redir;
            end else begin
                if (w_grant_fetch) begin
                    r_fetch_pc <= w_pc_seq;
                    r_wptr     <= r_wptr + PtrW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PtrW'(1);
                end
                if (w_grant_fetch && !w_pop) begin
                    r_count <= r_count + CntW'(1);
                end else if (!w_grant_fetch && w_pop) begin
                    r_count <= r_count - CntW'(1);
                end
            end
        end
    end

    // FIFO storage carries no reset; entries are only read while counted valid.
    always_ff @(posedge clock) begin
        if (!reset && w_grant_fetch) begin
            r_fifo_inst[r_wptr] <= mem_data;
            r_fifo_pc[r_wptr]   <= r_fetch_pc;
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
module tb_imem_fetch_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;

    logic [31:0] mem [256];

    int n_checks;
    int n_errors;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        chk;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] maddr;
    } vec_t;

    vec_t vq[$];

    imem_fetch_arbiter #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (4),
        .MEM_WORDS (256)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_ack     (dbg_ack),
        .dbg_data    (dbg_data)
    );

    // Combinational instruction memory, word index = address >> 2.
    assign mem_data = mem[mem_addr[9:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rdy, input logic c, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] ma);
        vec_t t;
        t.rst = rst; t.rdy = rdy; t.chk = c; t.valid = v;
        t.pc = pc; t.ins = ins; t.maddr = ma;
        vq.push_back(t);
    endtask

    // Drive inputs just after a rising edge, then wait for the sampling edge.
    task automatic drive(input logic rst, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic dreq, input logic [31:0] daddr);
        reset = rst; redirect = rd; redirect_pc = rpc;
        inst_ready = rdy; dbg_req = dreq; dbg_addr = daddr;
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_head(input string name, input logic [31:0] pc, input logic [31:0] ins);
        chk({name, " valid"}, {31'd0, inst_valid}, 32'd1);
        chk({name, " pc"}, inst_pc, pc);
        chk({name, " inst"}, inst, ins);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;

        // Streaming from reset, one instruction per cycle.
        add(0, 1, 1, 0, 32'h0, 32'h0,    32'h0);
        add(0, 1, 1, 1, 32'h0, 32'h1000, 32'h4);
        add(0, 1, 1, 1, 32'h4, 32'h1001, 32'h8);
        add(0, 1, 1, 1, 32'h8, 32'h1002, 32'hC);
        add(1, 1, 0, 0, 32'h0, 32'h0,    32'h0);
        // Stall from reset: FIFO fills to 4, fetch_pc holds at 0x10.
        add(0, 0, 1, 0, 32'h0, 32'h0,    32'h0);
        add(0, 0, 1, 1, 32'h0, 32'h1000, 32'h4);
        add(0, 0, 1, 1, 32'h0, 32'h1000, 32'h8);
        add(0, 0, 1, 1, 32'h0, 32'h1000, 32'hC);
        for (int k = 0; k < 6; k++) add(0, 0, 1, 1, 32'h0, 32'h1000, 32'h10);
        // Release: drain in order, refetch resumes one cycle after the first pop.
        add(0, 1, 1, 1, 32'h0,  32'h1000, 32'h10);
        add(0, 1, 1, 1, 32'h4,  32'h1001, 32'h10);
        add(0, 1, 1, 1, 32'h8,  32'h1002, 32'h14);
        add(0, 1, 1, 1, 32'hC,  32'h1003, 32'h18);
        add(0, 1, 1, 1, 32'h10, 32'h1004, 32'h1C);
        add(0, 1, 1, 1, 32'h14, 32'h1005, 32'h20);

        drive(1, 0, 32'h0, 1, 0, 32'h0);
        adv();
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        adv();

        foreach (vq[i]) begin
            drive(vq[i].rst, 0, 32'h0, vq[i].rdy, 0, 32'h0);
            if (vq[i].chk) begin
                chk($sformatf("vec%0d valid", i), {31'd0, inst_valid}, {31'd0, vq[i].valid});
                if (vq[i].valid) begin
                    chk($sformatf("vec%0d pc", i), inst_pc, vq[i].pc);
                    chk($sformatf("vec%0d inst", i), inst, vq[i].ins);
                end
                chk($sformatf("vec%0d mem_addr", i), mem_addr, vq[i].maddr);
                chk($sformatf("vec%0d dbg_ack", i), {31'd0, dbg_ack}, 32'd0);
                chk($sformatf("vec%0d dbg_data", i), dbg_data, 32'd0);
            end
            adv();
        end

        // Redirect with 3 entries (0x18, 0x1C, 0x20) buffered, misaligned target.
        drive(0, 1, 32'h41, 1, 0, 32'h0);
        chk_head("redir pre", 32'h18, 32'h1006);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("redir+1 valid", {31'd0, inst_valid}, 32'd0);
        chk("redir+1 mem_addr", mem_addr, 32'h40);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_head("redir+2", 32'h40, 32'h1010);
        chk("redir+2 mem_addr", mem_addr, 32'h44);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_head("redir+3", 32'h44, 32'h1011);
        adv();

        // Debug held with misaligned address while fetch streams: grants alternate.
        drive(0, 0, 32'h0, 1, 1, 32'h23);
        chk("dbg0 mem_addr", mem_addr, 32'h20);
        chk("dbg0 ack", {31'd0, dbg_ack}, 32'd0);
        chk_head("dbg0", 32'h48, 32'h1012);
        adv();
        drive(0, 0, 32'h0, 1, 1, 32'h23);
        chk("dbg1 ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg1 data", dbg_data, 32'h1008);
        chk("dbg1 mem_addr", mem_addr, 32'h4C);
        chk("dbg1 valid", {31'd0, inst_valid}, 32'd0);
        adv();
        drive(0, 0, 32'h0, 1, 1, 32'h23);
        chk("dbg2 ack", {31'd0, dbg_ack}, 32'd0);
        chk("dbg2 mem_addr", mem_addr, 32'h20);
        chk_head("dbg2", 32'h4C, 32'h1013);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h23);
        chk("dbg3 ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg3 data", dbg_data, 32'h1008);
        chk("dbg3 mem_addr", mem_addr, 32'h50);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("dbg4 ack", {31'd0, dbg_ack}, 32'd0);
        chk_head("dbg4", 32'h50, 32'h1014);
        adv();

        // Redirect near the top of memory: fetch wraps 0x3FC -> 0x000.
        drive(0, 1, 32'h3F8, 1, 0, 32'h0);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("wrap+1 valid", {31'd0, inst_valid}, 32'd0);
        chk("wrap+1 mem_addr", mem_addr, 32'h3F8);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_head("wrap+2", 32'h3F8, 32'h10FE);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_head("wrap+3", 32'h3FC, 32'h10FF);
        chk("wrap+3 mem_addr", mem_addr, 32'h0);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_head("wrap+4", 32'h0, 32'h1000);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_head("wrap+5", 32'h4, 32'h1001);
        adv();

        // Fill the FIFO (head 0x8), then reset while a debug read is granted.
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 32'h0, 0, 0, 32'h0);
            adv();
        end
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("full mem_addr", mem_addr, 32'h18);
        chk_head("full", 32'h8, 32'h1002);
        adv();
        drive(1, 0, 32'h0, 0, 1, 32'h20);
        chk("rst dbg grant mem_addr", mem_addr, 32'h20);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk("post rst valid", {31'd0, inst_valid}, 32'd0);
        chk("post rst ack", {31'd0, dbg_ack}, 32'd0);
        chk("post rst dbg_data", dbg_data, 32'd0);
        chk("post rst mem_addr", mem_addr, 32'h0);
        adv();
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        chk_head("post rst+1", 32'h0, 32'h1000);
        chk("post rst+1 ack", {31'd0, dbg_ack}, 32'd0);
        adv();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
